// File: rtl/note_roll_engine_pkg.sv
// Shared definitions for the note roll engine: FSM encoding, default colour and
// helpers that derive the note record layout {key, start, end} from the parameters.
package note_roll_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECORD,
      ST_FETCH,
      ST_LINE,
      ST_PIXEL,
      ST_NEXT,
      ST_DONE
   } state_e;

   localparam logic [23:0] DEFAULT_COLOUR = 24'h0000FF;

   function automatic int key_width(input int num_keys);
      return (num_keys > 1) ? $clog2(num_keys) : 1;
   endfunction

   // Record layout, LSB first: end timestamp, start timestamp, key index.
   function automatic int end_lsb();
      return 0;
   endfunction

   function automatic int start_lsb(input int ts_w);
      return ts_w;
   endfunction

   function automatic int key_lsb(input int ts_w);
      return 2 * ts_w;
   endfunction

   function automatic int rec_width(input int num_keys, input int ts_w);
      return key_width(num_keys) + 2 * ts_w;
   endfunction

endpackage

// File: rtl/note_roll_engine_ram.sv
// Note storage: simple dual-port RAM with one write port and one synchronous read port.
// Contents are deliberately not reset so a recording survives a reset.
module note_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/note_roll_engine.sv
// Polyphonic note recorder and falling-block renderer: records per-key press/release
// timestamps into note RAM and redraws every stored note as a lane rectangle, one pixel per cycle.
module note_roll_engine
   import note_roll_engine_pkg::*;
#(
   parameter int          NUM_KEYS   = 24,
   parameter int          DEPTH      = 128,
   parameter int          TS_W       = 29,
   parameter int          CLK_PER_US = 50,
   parameter int          SHIFT      = 20,
   parameter int          BASE_Y     = 92,
   parameter int          LANE_W     = 6,
   parameter logic [23:0] COLOUR     = DEFAULT_COLOUR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_KEYS-1:0]      keyState,
   input  logic                     recordEn,
   input  logic                     playStart,
   input  logic                     frameReq,
   output logic [7:0]               outX,
   output logic [7:0]               outY,
   output logic [23:0]              outColour,
   output logic                     pixelValid,
   output logic                     doneDrawing,
   output logic [$clog2(DEPTH):0]   noteCount,
   output logic                     overflow
);

   localparam int KEY_W  = key_width(NUM_KEYS);
   localparam int REC_W  = rec_width(NUM_KEYS, TS_W);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   state_e              state_q, state_d;
   logic [PRE_W-1:0]    presc_q, presc_d;
   logic [TS_W-1:0]     ts_now_q, ts_now_d;
   logic                rec_en_q;
   logic [NUM_KEYS-1:0] key_q;
   logic [NUM_KEYS-1:0] active_q, active_d;
   logic [NUM_KEYS-1:0] pending_q, pending_d;
   logic [TS_W-1:0]     start_ts_q [NUM_KEYS];
   logic [TS_W-1:0]     start_ts_d [NUM_KEYS];
   logic [TS_W-1:0]     end_ts_q [NUM_KEYS];
   logic [TS_W-1:0]     end_ts_d [NUM_KEYS];
   logic [CNT_W-1:0]    note_count_q, note_count_d;
   logic                overflow_q, overflow_d;
   logic [CNT_W-1:0]    addr_q, addr_d;
   logic [7:0]          x_base_q, x_base_d;
   logic [7:0]          x_q, x_d;
   logic [7:0]          y_q, y_d;
   logic [7:0]          y_last_q, y_last_d;

   logic                timer_clr;
   logic                rec_enter;
   logic                rec_live;
   logic [NUM_KEYS-1:0] key_rise;
   logic [NUM_KEYS-1:0] key_fall;
   logic                drain_found;
   logic [NUM_KEYS-1:0] drain_onehot;
   logic [KEY_W-1:0]    drain_key;
   logic [TS_W-1:0]     drain_start;
   logic [TS_W-1:0]     drain_end;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [REC_W-1:0]    wr_data;
   logic [REC_W-1:0]    rd_data;
   logic [KEY_W-1:0]    rd_key;
   logic [TS_W-1:0]     rd_start;
   logic [TS_W-1:0]     rd_end;
   logic [TS_W-1:0]     age_s;
   logic [TS_W-1:0]     age_e;

   assign timer_clr = (recordEn & ~rec_en_q) | (playStart & (state_q != ST_RECORD));
   assign rec_enter = recordEn & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign rec_live  = (state_q == ST_RECORD);
   assign key_rise  = keyState & ~key_q;
   assign key_fall  = ~keyState & key_q;

   always_comb begin
      presc_d  = presc_q;
      ts_now_d = ts_now_q;
      if (timer_clr) begin
         presc_d  = '0;
         ts_now_d = '0;
      end else if (presc_q == PRE_W'(CLK_PER_US - 1)) begin
         presc_d  = '0;
         ts_now_d = ts_now_q + TS_W'(1);
      end else begin
         presc_d = presc_q + PRE_W'(1);
      end
   end

   // Lowest pending release wins the single write slot this cycle.
   always_comb begin
      drain_found  = 1'b0;
      drain_onehot = '0;
      drain_key    = '0;
      drain_start  = '0;
      drain_end    = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (!drain_found && pending_q[k]) begin
            drain_found     = 1'b1;
            drain_onehot[k] = 1'b1;
            drain_key       = KEY_W'(k);
            drain_start     = start_ts_q[k];
            drain_end       = end_ts_q[k];
         end
      end
   end

   always_comb begin
      active_d     = active_q;
      pending_d    = pending_q;
      start_ts_d   = start_ts_q;
      end_ts_d     = end_ts_q;
      note_count_d = note_count_q;
      overflow_d   = overflow_q;
      wr_en        = 1'b0;
      wr_addr      = note_count_q[ADDR_W-1:0];
      wr_data      = {drain_key, drain_start, drain_end};
      if (rec_enter) begin
         active_d     = '0;
         pending_d    = '0;
         note_count_d = '0;
         overflow_d   = 1'b0;
      end else begin
         // End time is latched at release so serialised writes keep the true release time.
         if (rec_live) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
               if (key_rise[k]) begin
                  start_ts_d[k] = ts_now_q;
                  active_d[k]   = 1'b1;
               end else if (key_fall[k] && active_q[k]) begin
                  end_ts_d[k]  = ts_now_q;
                  active_d[k]  = 1'b0;
                  pending_d[k] = 1'b1;
               end
            end
            if (!recordEn) begin
               active_d = '0;
            end
         end
         if (drain_found) begin
            pending_d = pending_d & ~drain_onehot;
            if (note_count_q == CNT_W'(DEPTH)) begin
               overflow_d = 1'b1;
            end else begin
               wr_en        = 1'b1;
               note_count_d = note_count_q + CNT_W'(1);
            end
         end
      end
   end

   assign rd_key   = rd_data[key_lsb(TS_W) +: KEY_W];
   assign rd_start = rd_data[start_lsb(TS_W) +: TS_W];
   assign rd_end   = rd_data[end_lsb() +: TS_W];
   assign age_s    = (ts_now_q - rd_start) >> SHIFT;
   assign age_e    = (ts_now_q - rd_end) >> SHIFT;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      x_base_d = x_base_q;
      x_d      = x_q;
      y_d      = y_q;
      y_last_d = y_last_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (recordEn) begin
               state_d = ST_RECORD;
            end else if (playStart || frameReq) begin
               state_d = ST_FETCH;
               addr_d  = '0;
            end
         end
         ST_RECORD: begin
            if (!recordEn) begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_d = (addr_q == note_count_q) ? ST_DONE : ST_LINE;
         end
         // The current timer value is used once here, so the whole block shares one snapshot.
         ST_LINE: begin
            if (age_e > TS_W'(BASE_Y)) begin
               state_d = ST_NEXT;
            end else begin
               state_d  = ST_PIXEL;
               x_base_d = 8'(rd_key) * 8'(LANE_W);
               x_d      = 8'(rd_key) * 8'(LANE_W);
               y_d      = (age_s > TS_W'(BASE_Y)) ? 8'd0 : 8'(BASE_Y) - age_s[7:0];
               y_last_d = 8'(BASE_Y) - age_e[7:0];
            end
         end
         ST_PIXEL: begin
            if (x_q == x_base_q + 8'(LANE_W - 2)) begin
               x_d = x_base_q;
               if (y_q == y_last_q) begin
                  state_d = ST_NEXT;
               end else begin
                  y_d = y_q + 8'd1;
               end
            end else begin
               x_d = x_q + 8'd1;
            end
         end
         ST_NEXT: begin
            addr_d  = addr_q + CNT_W'(1);
            state_d = ST_FETCH;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         ts_now_q     <= '0;
         rec_en_q     <= 1'b0;
         key_q        <= '0;
         active_q     <= '0;
         pending_q    <= '0;
         note_count_q <= '0;
         overflow_q   <= 1'b0;
         addr_q       <= '0;
         x_base_q     <= '0;
         x_q          <= '0;
         y_q          <= '0;
         y_last_q     <= '0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         ts_now_q     <= ts_now_d;
         rec_en_q     <= recordEn;
         key_q        <= keyState;
         active_q     <= active_d;
         pending_q    <= pending_d;
         note_count_q <= note_count_d;
         overflow_q   <= overflow_d;
         addr_q       <= addr_d;
         x_base_q     <= x_base_d;
         x_q          <= x_d;
         y_q          <= y_d;
         y_last_q     <= y_last_d;
      end
   end

   // Timestamps are only meaningful once qualified by active/pending, so they need no reset.
   always_ff @(posedge clk) begin
      start_ts_q <= start_ts_d;
      end_ts_q   <= end_ts_d;
   end

   note_ram #(
      .WIDTH  (REC_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (addr_q[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   assign pixelValid  = (state_q == ST_PIXEL);
   assign outX        = pixelValid ? x_q : 8'd0;
   assign outY        = pixelValid ? y_q : 8'd0;
   assign outColour   = pixelValid ? COLOUR : 24'd0;
   assign doneDrawing = (state_q == ST_DONE);
   assign noteCount   = note_count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_note_roll_engine.sv
// Directed bench for note_roll_engine: a small, fast-timer instance (1 tick per clock,
// no row shift, 4-entry RAM) so expected timestamps and pixel rows can be worked out by hand.
module tb_note_roll_engine;

   localparam int NUM_KEYS   = 8;
   localparam int DEPTH      = 4;
   localparam int TS_W       = 16;
   localparam int CLK_PER_US = 1;
   localparam int SHIFT      = 0;
   localparam int BASE_Y     = 92;
   localparam int LANE_W     = 6;
   localparam logic [23:0] BLOCK_COLOUR = 24'h0000FF;

   logic                clk = 1'b0;
   logic                reset;
   logic [NUM_KEYS-1:0] keyState;
   logic                recordEn;
   logic                playStart;
   logic                frameReq;
   logic [7:0]          outX;
   logic [7:0]          outY;
   logic [23:0]         outColour;
   logic                pixelValid;
   logic                doneDrawing;
   logic [2:0]          noteCount;
   logic                overflow;

   int checkCount = 0;
   int passCount  = 0;
   int tsModel    = 0;
   int expX[$];
   int expY[$];

   note_roll_engine #(
      .NUM_KEYS   (NUM_KEYS),
      .DEPTH      (DEPTH),
      .TS_W       (TS_W),
      .CLK_PER_US (CLK_PER_US),
      .SHIFT      (SHIFT),
      .BASE_Y     (BASE_Y),
      .LANE_W     (LANE_W),
      .COLOUR     (BLOCK_COLOUR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .keyState    (keyState),
      .recordEn    (recordEn),
      .playStart   (playStart),
      .frameReq    (frameReq),
      .outX        (outX),
      .outY        (outY),
      .outColour   (outColour),
      .pixelValid  (pixelValid),
      .doneDrawing (doneDrawing),
      .noteCount   (noteCount),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; tsModel mirrors the DUT timer at each falling edge.
   task automatic stepCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         tsModel++;
      end
   endtask

   task automatic applyStimulus(input logic [NUM_KEYS-1:0] keys, input logic rec,
                                input logic play, input logic frame);
      keyState  = keys;
      recordEn  = rec;
      playStart = play;
      frameReq  = frame;
   endtask

   function automatic logic [63:0] mkRec(input int key, input int startTs, input int endTs);
      logic [2:0]  k;
      logic [15:0] s;
      logic [15:0] e;
      k = 3'(key);
      s = 16'(startTs);
      e = 16'(endTs);
      return 64'({k, s, e});
   endfunction

   task automatic addBlock(input int key, input int yFirst, input int yLast);
      for (int y = yFirst; y <= yLast; y++) begin
         for (int x = key * LANE_W; x <= key * LANE_W + LANE_W - 2; x++) begin
            expX.push_back(x);
            expY.push_back(y);
         end
      end
   endtask

   task automatic runFrame(input string tag);
      int pix = 0;
      bit doneSeen = 1'b0;
      for (int c = 0; c < 300 && !doneSeen; c++) begin
         stepCycles(1);
         if (pixelValid) begin
            if (pix < expX.size()) begin
               checkOutput($sformatf("%s_x%0d", tag, pix), 64'(outX), 64'(expX[pix]));
               checkOutput($sformatf("%s_y%0d", tag, pix), 64'(outY), 64'(expY[pix]));
               checkOutput($sformatf("%s_col%0d", tag, pix), 64'(outColour), 64'(BLOCK_COLOUR));
            end else begin
               checkOutput($sformatf("%s_extra%0d", tag, pix), 64'(pixelValid), 64'(0));
            end
            pix++;
         end
         if (doneDrawing) begin
            doneSeen = 1'b1;
         end
      end
      checkOutput({tag, "_count"}, 64'(pix), 64'(expX.size()));
      checkOutput({tag, "_done"}, 64'(doneSeen), 64'(1));
      expX.delete();
      expY.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      stepCycles(3);
      checkOutput("rst_pixelValid", 64'(pixelValid), 64'(0));
      checkOutput("rst_outX", 64'(outX), 64'(0));
      checkOutput("rst_outY", 64'(outY), 64'(0));
      checkOutput("rst_outColour", 64'(outColour), 64'(0));
      checkOutput("rst_done", 64'(doneDrawing), 64'(0));
      checkOutput("rst_noteCount", 64'(noteCount), 64'(0));
      checkOutput("rst_overflow", 64'(overflow), 64'(0));
      reset = 1'b0;
      stepCycles(1);

      // Empty RAM: FETCH then DONE
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      checkOutput("empty_done_c1", 64'(doneDrawing), 64'(0));
      stepCycles(1);
      checkOutput("empty_done_c2", 64'(doneDrawing), 64'(1));

      // Record session 1
      applyStimulus('0, 1'b1, 1'b0, 1'b0);
      stepCycles(1);
      tsModel = 0;
      stepCycles(10);
      applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
      stepCycles(5);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      stepCycles(1);
      checkOutput("rec1_count_pending", 64'(noteCount), 64'(0));
      stepCycles(1);
      checkOutput("rec1_count", 64'(noteCount), 64'(1));
      checkOutput("rec1_ram0", 64'(dut.u_ram.mem_q[0]), mkRec(3, 10, 15));

      stepCycles(3);
      applyStimulus(8'h84, 1'b1, 1'b0, 1'b0);
      stepCycles(5);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      stepCycles(2);
      checkOutput("simul_count_a", 64'(noteCount), 64'(2));
      checkOutput("simul_ram1", 64'(dut.u_ram.mem_q[1]), mkRec(2, 20, 25));
      stepCycles(1);
      checkOutput("simul_count_b", 64'(noteCount), 64'(3));
      checkOutput("simul_ram2", 64'(dut.u_ram.mem_q[2]), mkRec(7, 20, 25));

      stepCycles(2);
      applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
      stepCycles(2);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      stepCycles(3);
      checkOutput("full_count", 64'(noteCount), 64'(4));
      checkOutput("full_ram3", 64'(dut.u_ram.mem_q[3]), mkRec(0, 30, 32));
      checkOutput("full_overflow", 64'(overflow), 64'(0));
      applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
      stepCycles(2);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      stepCycles(3);
      checkOutput("ovf_count", 64'(noteCount), 64'(4));
      checkOutput("ovf_flag", 64'(overflow), 64'(1));
      checkOutput("ovf_ram3", 64'(dut.u_ram.mem_q[3]), mkRec(0, 30, 32));
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      stepCycles(2);
      checkOutput("ovf_sticky", 64'(overflow), 64'(1));

      // Record session 2: one note {1,0,2}, then render with the LINE snapshot at t=5
      applyStimulus('0, 1'b1, 1'b0, 1'b0);
      stepCycles(1);
      tsModel = 0;
      checkOutput("rec2_count_clr", 64'(noteCount), 64'(0));
      checkOutput("rec2_ovf_clr", 64'(overflow), 64'(0));
      applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
      stepCycles(2);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      stepCycles(1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("rec2_count", 64'(noteCount), 64'(1));
      checkOutput("rec2_ram0", 64'(dut.u_ram.mem_q[0]), mkRec(1, 0, 2));
      addBlock(1, 87, 89);
      runFrame("frame_t5");

      // Snapshot at t=94: start clamped to the top row, end exactly on it
      stepCycles(92 - tsModel);
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      addBlock(1, 0, 0);
      runFrame("frame_clip");

      // Note now entirely off screen
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      runFrame("frame_off");

      // playStart restarts the timer: the note lies in the future, nothing drawn
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      stepCycles(1);
      tsModel = 0;
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      runFrame("frame_play");

      // Frame with snapshot t=10 (rows 82..84), interrupted by reset mid-block
      stepCycles(8 - tsModel);
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
      stepCycles(2);
      checkOutput("mid_valid", 64'(pixelValid), 64'(1));
      checkOutput("mid_x0", 64'(outX), 64'(6));
      checkOutput("mid_y0", 64'(outY), 64'(82));
      stepCycles(1);
      checkOutput("mid_x1", 64'(outX), 64'(7));
      reset = 1'b1;
      stepCycles(1);
      checkOutput("rstmid_valid", 64'(pixelValid), 64'(0));
      checkOutput("rstmid_outX", 64'(outX), 64'(0));
      checkOutput("rstmid_outY", 64'(outY), 64'(0));
      checkOutput("rstmid_colour", 64'(outColour), 64'(0));
      checkOutput("rstmid_done", 64'(doneDrawing), 64'(0));
      checkOutput("rstmid_count", 64'(noteCount), 64'(0));
      checkOutput("rstmid_ram0", 64'(dut.u_ram.mem_q[0]), mkRec(1, 0, 2));
      reset = 1'b0;
      stepCycles(1);

      // Key still held when recording stops: the note is discarded
      applyStimulus('0, 1'b1, 1'b0, 1'b0);
      stepCycles(1);
      applyStimulus(8'h20, 1'b1, 1'b0, 1'b0);
      stepCycles(2);
      applyStimulus(8'h20, 1'b0, 1'b0, 1'b0);
      stepCycles(2);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      stepCycles(3);
      checkOutput("held_discard_count", 64'(noteCount), 64'(0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
